monpro_arbiter: RTL and testbench
=================================

Name: monpro_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one MonPro core among NUM_REQ modular-exponentiation channels.
- Grants the core to one requester at a time and streams that requester's operand words into the core: operand A first, then operand B.
- Holds the core's start for the whole operation, waits for completion, then routes the TOTAL_ADDR result words back to the granted requester.
- Sits between the ModExp channel controllers and the single MonPro instance.

Parameters:
DATA_WIDTH, 64, bits per operand word
TOTAL_ADDR, 32, words per operand/result
NUM_REQ, 2, number of requesters (2..8)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
req  input  NUM_REQ  per-requester operation request, level
req_valid  input  NUM_REQ  per-requester operand word valid
req_data  input  NUM_REQ*DATA_WIDTH  per-requester operand word; requester k uses bits [k*DATA_WIDTH +: DATA_WIDTH]
gnt  output  NUM_REQ  one-hot grant, registered
busy  output  1  high in any state except IDLE
mp_start  output  1  start to MonPro
mp_inp  output  DATA_WIDTH  operand word to MonPro
mp_inp_valid  output  1  mp_inp valid this cycle
mp_done  input  1  MonPro result ready; one-cycle pulse, equivalent to state == WRITEOUT
mp_outp  input  DATA_WIDTH  MonPro result word, one per cycle after mp_done
rsp_valid  output  1  result word valid
rsp_data  output  DATA_WIDTH  result word
rsp_last  output  1  marks the final result word
rsp_id  output  3  index of the requester owning rsp_data

Behaviour:
- Reset (async): state=IDLE; rr_ptr=0; word_cnt=0; all outputs 0.
- FSM states: IDLE, LOAD, WAIT, DRAIN.
- IDLE:
  - If req is nonzero, select the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Next cycle: gnt=onehot(sel), mp_start=1, state=LOAD, word_cnt=0.
  - If req is zero, stay in IDLE.
- LOAD:
  - Each cycle that req_valid[sel] is high: mp_inp<=req_data[sel], mp_inp_valid<=1, word_cnt++.
  - A cycle with req_valid[sel] low gives mp_inp_valid=0, mp_inp holds its value, and the counter stalls.
  - When word_cnt reaches 2*TOTAL_ADDR (A words 0..TOTAL_ADDR-1, then B words): state=WAIT, word_cnt=0.
  - req_valid from non-granted requesters is ignored.
  - mp_done seen in LOAD is ignored.
- WAIT: mp_inp_valid=0, mp_inp=0. mp_done moves the FSM to DRAIN.
- DRAIN:
  - Each cycle: rsp_data<=mp_outp, rsp_valid<=1, rsp_id<=sel, word_cnt++.
  - rsp_last=1 on word TOTAL_ADDR-1, which is the final DRAIN cycle.
  - Result latency: first rsp_valid occurs 1 cycle after the cycle mp_outp word 0 is presented.
  - There is no backpressure; requesters must accept every word.
- Exit from DRAIN:
  - Next cycle: state=IDLE, gnt=0, mp_start=0, rsp_valid=0, rsp_last=0.
  - rr_ptr=(sel+1) mod NUM_REQ.
- Minimum turnaround: a new grant can be asserted 2 cycles after rsp_last.
- Dropping req after grant does not abort; the operation completes. Requests are sampled only in IDLE.
- Simultaneous requests: round-robin guarantees each requester is served at most NUM_REQ-1 operations after it first requests.
- gnt is one-hot or zero, never multi-hot.
- rsp_id width is fixed at 3; upper bits are 0 when NUM_REQ<8.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The MonPro core sees mp_start fall and is reset by the same reset.

Test Plan:
- Single requester, NUM_REQ=2: req[0]=1 with 64 back-to-back words 1..64; mp_done pulse followed by mp_outp words 0xA0..0xBF. Required: gnt=01 one cycle after req; mp_inp_valid for exactly 64 cycles; rsp_valid for 32 cycles with rsp_id=0 and rsp_last on 0xBF; gnt=00 afterwards.
- Both requesters active from reset: grants ordered 0,1,0,1 across four operations, each op completing fully before the next gnt.
- req_valid gaps: requester 1 drops req_valid every 3rd cycle. Required: mp_inp_valid count stays exactly 64 and WAIT is entered only after the 64th valid word.
- mp_done pulsed during LOAD: ignored. FSM stays in LOAD and DRAIN starts only after a pulse in WAIT.
- Reset asserted at LOAD word 20: all outputs 0 asynchronously. After release with req[1]=1, the grant goes to requester 1 (rr_ptr=0, req[0]=0) and the word count restarts at 0.
- req[0] deasserted mid-LOAD: the operation still completes with 32 rsp words, then the arbiter returns to IDLE.

Source files
------------

// File: rtl/monpro_arbiter.sv
// monpro_arbiter
//
// Shares a single MonPro core between NUM_REQ modular-exponentiation
// channels. An idle arbiter picks a requester round-robin, streams that
// requester's 2*TOTAL_ADDR operand words (A then B) into the core, waits
// for the core to finish and then forwards the TOTAL_ADDR result words
// back, tagged with the owner's index.
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   req            per-requester operation request (level, sampled in IDLE)
//   req_valid      per-requester operand word valid
//   req_data       packed operand words, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   gnt            registered one-hot grant
//   busy           high whenever an operation is in progress
//   mp_start       held high to the core for the whole operation
//   mp_inp         operand word to the core, qualified by mp_inp_valid
//   mp_done        one-cycle completion pulse from the core
//   mp_outp        result word from the core, one per cycle after mp_done
//   rsp_valid      result word valid, rsp_data carries it
//   rsp_last       marks the final result word
//   rsp_id         index of the requester owning rsp_data

module monpro_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int TOTAL_ADDR = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          busy,
    output logic                          mp_start,
    output logic [DATA_WIDTH-1:0]         mp_inp,
    output logic                          mp_inp_valid,
    input  logic                          mp_done,
    input  logic [DATA_WIDTH-1:0]         mp_outp,
    output logic                          rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_last,
    output logic [2:0]                    rsp_id
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam int CNT_W = $clog2(2*TOTAL_ADDR + 1);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(2*TOTAL_ADDR - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(TOTAL_ADDR - 1);
    localparam logic [CNT_W-1:0] DRAIN_END  = CNT_W'(TOTAL_ADDR);

    logic [1:0]            state;
    logic [2:0]            sel;
    logic [2:0]            rr_ptr;
    logic [CNT_W-1:0]      word_cnt;

    logic [7:0]            req_pad;
    logic [3:0]            idx;
    logic [2:0]            pick;
    logic                  pick_found;
    logic [7:0]            onehot;
    logic [2:0]            next_ptr;
    logic [DATA_WIDTH-1:0] cur_data;
    logic                  cur_valid;

    assign busy     = (state != ST_IDLE);
    assign req_pad  = 8'(req);
    assign onehot   = 8'd1 << pick;
    assign next_ptr = (sel == 3'(NUM_REQ - 1)) ? 3'd0 : sel + 3'd1;

    // Round-robin search: walk the requesters starting at rr_ptr and wrap
    // modulo NUM_REQ; the first active request wins.
    always_comb begin
        pick       = 3'd0;
        pick_found = 1'b0;
        idx        = 4'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_ptr} + 4'(i);
            if (idx >= 4'(NUM_REQ)) begin
                idx = idx - 4'(NUM_REQ);
            end
            if (!pick_found && req_pad[idx[2:0]]) begin
                pick       = idx[2:0];
                pick_found = 1'b1;
            end
        end
    end

    // Operand word/valid of the granted requester; everyone else is ignored.
    always_comb begin
        cur_data  = '0;
        cur_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel == 3'(k)) begin
                cur_data  = req_data[k*DATA_WIDTH +: DATA_WIDTH];
                cur_valid = req_valid[k];
            end
        end
    end

    // Sequencer. DRAIN runs for TOTAL_ADDR+1 cycles: TOTAL_ADDR cycles
    // capture result words, and the extra cycle is the one in which the
    // registered rsp_last is visible, after which everything drops together.
    // That gives the two-cycle gap between rsp_last and the next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            sel          <= 3'd0;
            rr_ptr       <= 3'd0;
            word_cnt     <= '0;
            gnt          <= '0;
            mp_start     <= 1'b0;
            mp_inp       <= '0;
            mp_inp_valid <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_last     <= 1'b0;
            rsp_id       <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rsp_valid <= 1'b0;
                    rsp_last  <= 1'b0;
                    if (pick_found) begin
                        sel      <= pick;
                        gnt      <= onehot[NUM_REQ-1:0];
                        mp_start <= 1'b1;
                        word_cnt <= '0;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (cur_valid) begin
                        mp_inp       <= cur_data;
                        mp_inp_valid <= 1'b1;
                        if (word_cnt == LOAD_LAST) begin
                            word_cnt <= '0;
                            state    <= ST_WAIT;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end else begin
                        mp_inp_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    mp_inp_valid <= 1'b0;
                    mp_inp       <= '0;
                    if (mp_done) begin
                        word_cnt <= '0;
                        state    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (word_cnt == DRAIN_END) begin
                        state     <= ST_IDLE;
                        gnt       <= '0;
                        mp_start  <= 1'b0;
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        rr_ptr    <= next_ptr;
                        word_cnt  <= '0;
                    end else begin
                        rsp_data  <= mp_outp;
                        rsp_valid <= 1'b1;
                        rsp_id    <= sel;
                        rsp_last  <= (word_cnt == DRAIN_LAST);
                        word_cnt  <= word_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_monpro_arbiter.sv
// tb_monpro_arbiter
//
// Drives operations into monpro_arbiter while playing the MonPro core.
// Expected grants, operand words and result words are queued as they are
// issued; a monitor pops and compares whenever the DUT presents them.

module tb_monpro_arbiter;

    localparam int DW = 64;
    localparam int TA = 32;
    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     gnt;
    logic              busy;
    logic              mp_start;
    logic [DW-1:0]     mp_inp;
    logic              mp_inp_valid;
    logic              mp_done;
    logic [DW-1:0]     mp_outp;
    logic              rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_last;
    logic [2:0]        rsp_id;

    monpro_arbiter #(.DATA_WIDTH(DW), .TOTAL_ADDR(TA), .NUM_REQ(NR)) dut (
        .clk(clk), .reset(reset), .req(req), .req_valid(req_valid),
        .req_data(req_data), .gnt(gnt), .busy(busy), .mp_start(mp_start),
        .mp_inp(mp_inp), .mp_inp_valid(mp_inp_valid), .mp_done(mp_done),
        .mp_outp(mp_outp), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [2:0]    id;
        logic          last;
        int            cyc;
    } rsp_t;

    rsp_t          exp_rsp_q[$];
    logic [DW-1:0] exp_inp_q[$];
    int            exp_inp_cyc_q[$];
    int            exp_gnt_q[$];
    int            exp_gnt_cyc_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int model_ptr = 0;

    // Round-robin rule: first active request at or after the pointer, wrapping.
    function automatic int rrPick(logic [NR-1:0] r, int ptr);
        for (int i = 0; i < NR; i++) begin
            int j;
            j = (ptr + i) % NR;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finishTb();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    task automatic timeoutFail(input string name);
        n_cmp++;
        n_err++;
        $display("[TB] FAIL %s: timed out at cycle %0d", name, cyc);
        finishTb();
    endtask

    task automatic resetDut();
        reset = 1'b1;
        req = '0;
        req_valid = '0;
        mp_done = 1'b0;
        mp_outp = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_ptr = 0;
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant,
    // an operand word or a result word.
    logic [NR-1:0] prev_gnt = '0;
    bit            after_last = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_gnt = '0;
                after_last = 1'b0;
            end else begin
                checkOutput("gnt_onehot", 128'($countones(gnt) <= 1), 128'(1));
                checkOutput("mp_start_with_gnt", 128'(mp_start), 128'(gnt != '0));
                if (after_last) begin
                    checkOutput("idle_after_last", {gnt, rsp_valid, rsp_last, busy}, 0);
                    after_last = 1'b0;
                end
                if (gnt != '0 && prev_gnt == '0) begin
                    if (exp_gnt_q.size() == 0) begin
                        timeoutMsg("gnt_unexpected");
                    end else begin
                        int g, c;
                        g = exp_gnt_q.pop_front();
                        c = exp_gnt_cyc_q.pop_front();
                        checkOutput("gnt", 128'(gnt), 128'(1) << g);
                        if (c >= 0) checkOutput("gnt_latency", 128'(cyc), 128'(c));
                    end
                end
                if (mp_inp_valid) begin
                    if (exp_inp_q.size() == 0) begin
                        timeoutMsg("mp_inp_unexpected");
                    end else begin
                        logic [DW-1:0] e;
                        int ec;
                        e = exp_inp_q.pop_front();
                        ec = exp_inp_cyc_q.pop_front();
                        checkOutput("mp_inp", 128'(mp_inp), 128'(e));
                        checkOutput("mp_inp_latency", 128'(cyc), 128'(ec));
                    end
                end
                if (rsp_valid) begin
                    if (exp_rsp_q.size() == 0) begin
                        timeoutMsg("rsp_unexpected");
                    end else begin
                        rsp_t r;
                        r = exp_rsp_q.pop_front();
                        checkOutput("rsp_word", {rsp_data, rsp_id, rsp_last}, {r.data, r.id, r.last});
                        checkOutput("rsp_latency", 128'(cyc), 128'(r.cyc));
                        if (rsp_last) after_last = 1'b1;
                    end
                end
                prev_gnt = gnt;
            end
        end
    end

    task automatic timeoutMsg(input string name);
        n_cmp++;
        n_err++;
        $display("[TB] FAIL %s: DUT output with no expectation queued (cycle %0d)", name, cyc);
    endtask

    // One operation. gap_mode: 0 none, 1 every 3rd cycle idle, 2 random.
    // done_at/drop_at/reset_at trigger at that many accepted words (-1 = off).
    task automatic applyStimulus(input logic [NR-1:0] req_set, input int gap_mode,
                                 input int done_at, input int drop_at, input int reset_at,
                                 input bit det_data, input bit check_lat);
        int g, to, sent, cy;
        bit valid;
        logic [DW-1:0] w;
        @(posedge clk); #1;
        req = req_set;
        g = rrPick(req_set, model_ptr);
        exp_gnt_q.push_back(g);
        exp_gnt_cyc_q.push_back(check_lat ? cyc + 1 : -1);
        to = 0;
        while (gnt == '0 && to < 20) begin
            @(negedge clk);
            to++;
        end
        if (gnt == '0) timeoutFail("wait_gnt");

        sent = 0;
        cy = 0;
        while (sent < 2*TA) begin
            @(posedge clk); #1;
            mp_done = (done_at >= 0 && sent == done_at);
            if (drop_at >= 0 && sent == drop_at) req[g] = 1'b0;
            if (reset_at >= 0 && sent == reset_at) begin
                #1;
                reset = 1'b1;
                #1;
                checkOutput("reset_ctrl", {gnt, busy, mp_start, mp_inp_valid, rsp_valid, rsp_last, rsp_id}, 0);
                checkOutput("reset_data", {mp_inp, rsp_data}, 0);
                exp_inp_q.delete();
                exp_inp_cyc_q.delete();
                exp_rsp_q.delete();
                exp_gnt_q.delete();
                exp_gnt_cyc_q.delete();
                resetDut();
                return;
            end
            for (int k = 0; k < NR; k++) begin
                if (k != g) begin
                    req_valid[k] = 1'($urandom % 2);
                    req_data[k*DW +: DW] = {$urandom, $urandom};
                end
            end
            case (gap_mode)
                0: valid = 1'b1;
                1: valid = (cy % 3 != 2);
                default: valid = ($urandom % 4 != 0);
            endcase
            cy++;
            if (valid) begin
                w = det_data ? DW'(sent + 1) : {$urandom, $urandom};
                req_data[g*DW +: DW] = w;
                req_valid[g] = 1'b1;
                exp_inp_q.push_back(w);
                exp_inp_cyc_q.push_back(cyc + 1);
                sent++;
            end else begin
                req_valid[g] = 1'b0;
            end
        end

        @(posedge clk); #1;
        req_valid = '0;
        mp_done = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("wait_inp_cleared", {mp_inp_valid, mp_inp}, 0);
        checkOutput("wait_busy", 128'(busy), 128'(1));
        @(posedge clk); #1;
        mp_done = 1'b1;
        @(posedge clk); #1;
        mp_done = 1'b0;
        for (int k = 0; k < TA; k++) begin
            rsp_t r;
            w = det_data ? DW'(64'hA0 + k) : {$urandom, $urandom};
            mp_outp = w;
            r.data = w;
            r.id = 3'(g);
            r.last = (k == TA - 1);
            r.cyc = cyc + 1;
            exp_rsp_q.push_back(r);
            @(posedge clk); #1;
        end
        mp_outp = '0;
        model_ptr = (g + 1) % NR;

        to = 0;
        while (gnt != '0 && to < 20) begin
            @(negedge clk);
            to++;
        end
        if (gnt != '0) timeoutFail("wait_release");
        checkOutput("rsp_all_delivered", 128'(exp_rsp_q.size()), 0);
        checkOutput("inp_all_delivered", 128'(exp_inp_q.size()), 0);
    endtask

    initial begin
        #200000;
        timeoutFail("watchdog");
    end

    initial begin
        req = '0;
        req_valid = '0;
        req_data = '0;
        mp_done = 1'b0;
        mp_outp = '0;
        reset = 1'b1;
        #2;
        checkOutput("reset_ctrl_init", {gnt, busy, mp_start, mp_inp_valid, rsp_valid, rsp_last, rsp_id}, 0);
        checkOutput("reset_data_init", {mp_inp, rsp_data}, 0);
        resetDut();

        $display("[TB] single requester, deterministic words");
        applyStimulus(2'b01, 0, -1, -1, -1, 1'b1, 1'b1);
        req = '0;

        $display("[TB] both requesters from reset, four operations");
        resetDut();
        for (int n = 0; n < 4; n++) applyStimulus(2'b11, 2, -1, -1, -1, 1'b0, 1'b0);
        req = '0;

        $display("[TB] requester 1 with valid gaps");
        applyStimulus(2'b10, 1, -1, -1, -1, 1'b0, 1'b0);
        req = '0;

        $display("[TB] mp_done pulsed during load");
        applyStimulus(2'b01, 2, 30, -1, -1, 1'b0, 1'b0);
        req = '0;

        $display("[TB] reset at load word 20");
        applyStimulus(2'b01, 0, -1, -1, 20, 1'b0, 1'b0);
        applyStimulus(2'b10, 0, -1, -1, -1, 1'b0, 1'b1);
        req = '0;

        $display("[TB] req dropped mid-load");
        applyStimulus(2'b01, 2, -1, 10, -1, 1'b0, 1'b0);
        req = '0;
        repeat (3) @(negedge clk);
        checkOutput("idle_after_drop", {gnt, busy}, 0);

        $display("[TB] random request mixes");
        for (int n = 0; n < 4; n++) begin
            logic [NR-1:0] r;
            r = NR'($urandom_range(1, (1 << NR) - 1));
            applyStimulus(r, 2, -1, -1, -1, 1'b0, 1'b0);
            req = '0;
        end

        repeat (5) @(negedge clk);
        checkOutput("gnt_q_empty", 128'(exp_gnt_q.size()), 0);
        checkOutput("inp_q_empty", 128'(exp_inp_q.size()), 0);
        checkOutput("rsp_q_empty", 128'(exp_rsp_q.size()), 0);
        finishTb();
    end

endmodule
